// File: rtl/fft_result_streamer_if.sv
// Sample stream from fft_result_streamer to writeback/host: one complex float9 word pair per beat.
// A beat transfers when m_valid & m_ready; once m_valid rises, all m_* payload holds until that beat.
interface fft_result_streamer_if #(
  parameter int formatWidth = 9,
  parameter int IDX_W       = 5
);
  logic                   m_valid;
  logic                   m_ready;
  logic [formatWidth-1:0] m_real;
  logic [formatWidth-1:0] m_imag;
  logic [IDX_W-1:0]       m_index;
  logic                   m_last;

  modport master (output m_valid, m_real, m_imag, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_real, m_imag, m_index, m_last, output m_ready);
endinterface

// File: rtl/fft_result_streamer.sv
// Snapshots top_control's parallel FFT result on each fft_done rising edge and replays it as a stream.
// Optional macro FFT_BITREV_EN: emit captured words in bit-reversed order of the output position.
module fft_result_streamer #(
  parameter int formatWidth = 9,
  parameter int N_MAX       = 32,
  parameter int IDX_W       = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [10:0]                  fft_size,
  input  logic                         fft_done,
  input  logic [N_MAX*formatWidth-1:0] output_real,
  input  logic [N_MAX*formatWidth-1:0] output_imag,
  fft_result_streamer_if.master        m,
  output logic                         busy,
  output logic                         overrun,
  output logic                         dbg_state
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                 r_state;
  logic                   r_done_q;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_busy;
  logic                   r_overrun;
  logic [formatWidth-1:0] r_real;
  logic [formatWidth-1:0] r_imag;
  logic [IDX_W-1:0]       r_index;
  logic [IDX_W-1:0]       r_last_k;
  logic [formatWidth-1:0] r_snap_real [N_MAX];
  logic [formatWidth-1:0] r_snap_imag [N_MAX];

  logic             w_rise;
  logic             w_beat;
  logic             w_capture;
  logic             w_size_ok;
  logic [IDX_W-1:0] w_last_k_in;
  logic [IDX_W-1:0] w_k_next;
  logic [IDX_W-1:0] w_sel;

  assign w_rise    = fft_done & ~r_done_q;
  assign w_beat    = r_valid & m.m_ready;
  // A new frame is taken from IDLE, or on the final beat so streaming continues with no bubble.
  assign w_capture = w_rise & ((r_state == S_IDLE) | (w_beat & r_last));

  assign w_size_ok   = (fft_size >= 11'd2) && (fft_size <= 11'(N_MAX)) &&
                       ((fft_size & (fft_size - 11'd1)) == 11'd0);
  assign w_last_k_in = w_size_ok ? (fft_size[IDX_W-1:0] - IDX_W'(1)) : '1;
  assign w_k_next    = r_index + IDX_W'(1);

`ifdef FFT_BITREV_EN
  // r_last_k is size-1, so its popcount is log2(size): reverse all bits, then drop the unused low ones.
  function automatic logic [IDX_W-1:0] f_bitrev(input logic [IDX_W-1:0] k,
                                                input logic [IDX_W-1:0] last_k);
    logic [IDX_W-1:0] rev;
    int               n;
    n = 0;
    for (int i = 0; i < IDX_W; i++) begin
      rev[i] = k[IDX_W-1-i];
      n      = n + int'(last_k[i]);
    end
    return rev >> (IDX_W - n);
  endfunction

  assign w_sel = f_bitrev(w_k_next, r_last_k);
`else
  assign w_sel = w_k_next;
`endif

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < N_MAX; i++) begin
        r_snap_real[i] <= output_real[i*formatWidth +: formatWidth];
        r_snap_imag[i] <= output_imag[i*formatWidth +: formatWidth];
      end
    end
  end

  always_ff @(posedge clk) begin
    // Sampled even in reset so a level held high through reset is not mistaken for a new frame.
    r_done_q <= fft_done;
    if (rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_real    <= '0;
      r_imag    <= '0;
      r_index   <= '0;
      r_last_k  <= '0;
    end else if (w_capture) begin
      r_state  <= S_STREAM;
      r_valid  <= 1'b1;
      r_busy   <= 1'b1;
      r_last_k <= w_last_k_in;
      r_index  <= '0;
      r_last   <= 1'b0;
      r_real   <= output_real[0 +: formatWidth];
      r_imag   <= output_imag[0 +: formatWidth];
    end else if (r_state == S_STREAM) begin
      if (w_rise) begin
        r_overrun <= 1'b1;
      end
      if (w_beat) begin
        if (r_last) begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          r_index <= w_k_next;
          r_last  <= (w_k_next == r_last_k);
          r_real  <= r_snap_real[w_sel];
          r_imag  <= r_snap_imag[w_sel];
        end
      end
    end
  end

  assign m.m_valid = r_valid;
  assign m.m_real  = r_real;
  assign m.m_imag  = r_imag;
  assign m.m_index = r_index;
  assign m.m_last  = r_last;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
  assign dbg_state = (r_state == S_STREAM);

endmodule

// File: tb/tb_fft_result_streamer.sv
// Directed bench for fft_result_streamer: reset, natural/bit-reversed order, backpressure, overrun,
// back-to-back frames, size clamping and mid-frame reset.
module tb_fft_result_streamer;
  localparam int W  = 9;
  localparam int N  = 32;
  localparam int IW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [10:0]    fft_size;
  logic           fft_done;
  logic [N*W-1:0] output_real;
  logic [N*W-1:0] output_imag;
  logic           busy;
  logic           overrun;
  logic           dbg_state;

  fft_result_streamer_if #(.formatWidth(W), .IDX_W(IW)) s_if ();

  fft_result_streamer #(.formatWidth(W), .N_MAX(N), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .fft_size    (fft_size),
    .fft_done    (fft_done),
    .output_real (output_real),
    .output_imag (output_imag),
    .m           (s_if),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Output position k -> captured word index.
  function automatic int pos(input int k, input int n);
`ifdef FFT_BITREV_EN
    int lg;
    int r;
    lg = $clog2(n);
    r  = 0;
    for (int i = 0; i < lg; i++) r = r | (((k >> i) & 1) << (lg - 1 - i));
    return r;
`else
    if (n < 0) return 0;
    return k;
`endif
  endfunction

  task automatic fill(input logic [W-1:0] rb, input logic [W-1:0] ib);
    for (int i = 0; i < N; i++) begin
      output_real[i*W +: W] = rb | W'(i);
      output_imag[i*W +: W] = ib | W'(i);
    end
  endtask

  task automatic expect_frame(input int n, input logic [W-1:0] rb, input logic [W-1:0] ib);
    int w;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      w = pos(k, n);
      exp_q.push_back({ib | W'(w), rb | W'(w)});
    end
  endtask

  task automatic start_frame(input string tag, input logic [10:0] size);
    fft_size = size;
    fft_done = 1'b0;
    tick();
    fft_done = 1'b1;
    tick();
    chk($sformatf("%s_first_valid", tag), 32'(s_if.m_valid), 32'd1);
    chk($sformatf("%s_first_busy", tag), 32'(busy), 32'd1);
    fft_done = 1'b0;
  endtask

  task automatic stream_frame(input string tag, input int n, input bit stall);
    int beats;
    int cyc;
    beats = 0;
    cyc   = 0;
    while (beats < n && cyc < 4*n + 8) begin
      s_if.m_ready = stall ? (cyc % 3 == 0) : 1'b1;
      chk($sformatf("%s_valid_%0d", tag, beats), 32'(s_if.m_valid), 32'd1);
      chk($sformatf("%s_data_%0d", tag, beats), 32'({s_if.m_imag, s_if.m_real}), 32'(exp_q[0]));
      chk($sformatf("%s_index_%0d", tag, beats), 32'(s_if.m_index), 32'(beats));
      chk($sformatf("%s_last_%0d", tag, beats), 32'(s_if.m_last), 32'(beats == n - 1));
      if (s_if.m_ready) begin
        void'(exp_q.pop_front());
        beats++;
      end
      tick();
      cyc++;
    end
    s_if.m_ready = 1'b1;
    chk($sformatf("%s_beats", tag), 32'(beats), 32'(n));
    chk($sformatf("%s_end_valid", tag), 32'(s_if.m_valid), 32'd0);
    chk($sformatf("%s_end_busy", tag), 32'(busy), 32'd0);
  endtask

  int t6_tab[8];

  initial begin
`ifdef FFT_BITREV_EN
    t6_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    t6_tab = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    // T1: reset with fft_done held high
    rst          = 1'b1;
    fft_done     = 1'b1;
    fft_size     = 11'd32;
    s_if.m_ready = 1'b1;
    fill(9'h000, 9'h100);
    tick();
    tick();
    chk("t1_valid", 32'(s_if.m_valid), 32'd0);
    chk("t1_real", 32'(s_if.m_real), 32'd0);
    chk("t1_imag", 32'(s_if.m_imag), 32'd0);
    chk("t1_index", 32'(s_if.m_index), 32'd0);
    chk("t1_last", 32'(s_if.m_last), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_nocap_valid", 32'(s_if.m_valid), 32'd0);
      chk("t1_nocap_busy", 32'(busy), 32'd0);
    end

    // T2: natural 32-point frame, always ready
    expect_frame(32, 9'h000, 9'h100);
    start_frame("t2", 11'd32);
    stream_frame("t2", 32, 1'b0);
    chk("t2_idle_hold_real", 32'(s_if.m_real), 32'(pos(31, 32)));
    chk("t2_idle_hold_last", 32'(s_if.m_last), 32'd1);

    // T3: 8 points with ready pattern 1,0,0,1,...
    fill(9'h020, 9'h040);
    expect_frame(8, 9'h020, 9'h040);
    start_frame("t3", 11'd8);
    stream_frame("t3", 8, 1'b1);

    // T4: overrun at beat 10, back-to-back capture on the last beat
    fill(9'h000, 9'h100);
    start_frame("t4", 11'd32);
    for (int k = 0; k < 32; k++) begin
      s_if.m_ready = 1'b1;
      if (k == 10) begin
        fill(9'h080, 9'h180);
        fft_size = 11'd8;
      end
      fft_done = (k == 10 || k == 31);
      chk($sformatf("t4_real_%0d", k), 32'(s_if.m_real), 32'(pos(k, 32)));
      chk($sformatf("t4_imag_%0d", k), 32'(s_if.m_imag), 32'(9'h100 | 9'(pos(k, 32))));
      chk($sformatf("t4_index_%0d", k), 32'(s_if.m_index), 32'(k));
      chk($sformatf("t4_overrun_%0d", k), 32'(overrun), 32'(k > 10));
      tick();
    end
    fft_done = 1'b0;
    chk("t4_b2b_overrun", 32'(overrun), 32'd1);
    chk("t4_b2b_busy", 32'(busy), 32'd1);
    expect_frame(8, 9'h080, 9'h180);
    stream_frame("t4b", 8, 1'b0);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);

    // T5: size clamping
    fill(9'h000, 9'h100);
    expect_frame(32, 9'h000, 9'h100);
    start_frame("t5a", 11'd24);
    stream_frame("t5a", 32, 1'b0);
    fill(9'h0c0, 9'h1c0);
    expect_frame(2, 9'h0c0, 9'h1c0);
    start_frame("t5b", 11'd2);
    stream_frame("t5b", 2, 1'b0);

    // T6: 8-point ordering table, then reset at beat 3
    fill(9'h000, 9'h100);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back({9'h100 | 9'(t6_tab[k]), 9'(t6_tab[k])});
    start_frame("t6", 11'd8);
    stream_frame("t6", 8, 1'b0);
    start_frame("t6r", 11'd8);
    for (int k = 0; k < 4; k++) begin
      s_if.m_ready = 1'b1;
      chk($sformatf("t6r_real_%0d", k), 32'(s_if.m_real), 32'(t6_tab[k]));
      chk($sformatf("t6r_index_%0d", k), 32'(s_if.m_index), 32'(k));
      if (k == 3) rst = 1'b1;
      tick();
    end
    chk("t6r_valid", 32'(s_if.m_valid), 32'd0);
    chk("t6r_state_idle", 32'(dbg_state), 32'd0);
    chk("t6r_busy", 32'(busy), 32'd0);
    chk("t6r_index", 32'(s_if.m_index), 32'd0);
    chk("t6r_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6r_no_beats", 32'(s_if.m_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
